// File: rtl/hierarchy_result_acc.sv
// rtl/hierarchy_result_acc.sv - windowed four-channel accumulator behind the hierarchy_sub result buses.
// Accumulates y1..y4 over WINDOW accepted samples and holds one registered result per window.
module hierarchy_result_acc #(
  parameter int WIDTH    = 8,
  parameter int ACC_W    = 16,
  parameter int WINDOW   = 4,
  parameter int SIGNED_Y = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] y2,
  input  logic [WIDTH-1:0] y3,
  input  logic [WIDTH-1:0] y4,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum1,
  output logic [ACC_W-1:0] sum2,
  output logic [ACC_W-1:0] sum3,
  output logic [ACC_W-1:0] sum4,
  output logic [ACC_W-1:0] out_n,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WINDOW + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q [4];
  logic [ACC_W-1:0] acc_d [4];
  logic             win_ovf_q, win_ovf_d;
  logic [ACC_W-1:0] sum_q [4];
  logic [ACC_W-1:0] sum_d [4];
  logic [ACC_W-1:0] out_n_q, out_n_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] y_in [4];
  logic [ACC_W-1:0] ext  [4];
  logic [ACC_W:0]   wide [4];
  logic [3:0]       step_ovf;
  logic             accept;
  logic             last_beat;
  logic             emit;
  logic             beat_ovf;
  logic [CNT_W-1:0] cnt_inc;

  assign y_in[0] = y1;
  assign y_in[1] = y2;
  assign y_in[2] = y3;
  assign y_in[3] = y4;

  // y2/y3 are the adder results and may be two's complement; y1/y4 are raw bit patterns.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if ((SIGNED_Y != 0) && (i == 1 || i == 2)) begin
        ext[i]      = {{(ACC_W-WIDTH){y_in[i][WIDTH-1]}}, y_in[i]};
        wide[i]     = {1'b0, acc_q[i]} + {1'b0, ext[i]};
        step_ovf[i] = (acc_q[i][ACC_W-1] == ext[i][ACC_W-1]) &&
                      (wide[i][ACC_W-1] != acc_q[i][ACC_W-1]);
      end else begin
        ext[i]      = {{(ACC_W-WIDTH){1'b0}}, y_in[i]};
        wide[i]     = {1'b0, acc_q[i]} + {1'b0, ext[i]};
        step_ovf[i] = wide[i][ACC_W];
      end
    end
  end

  assign accept    = in_valid && in_ready_q;
  assign last_beat = accept && (cnt_q == CNT_W'(WINDOW - 1));
  assign emit      = last_beat || (in_ready_q && flush && ((cnt_q != '0) || accept));
  assign beat_ovf  = accept && (|step_ovf);
  assign cnt_inc   = cnt_q + CNT_W'(accept);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (emit) state_d = HOLD;
      HOLD:    if (out_valid_q && out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Handshake outputs are flops decoded from the next state, so out_ready never reaches in_ready combinationally.
  always_comb begin
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  always_comb begin
    cnt_d     = cnt_q;
    win_ovf_d = win_ovf_q;
    out_n_d   = out_n_q;
    ovf_d     = ovf_q;
    for (int i = 0; i < 4; i++) begin
      acc_d[i] = acc_q[i];
      sum_d[i] = sum_q[i];
    end
    if (accept) begin
      cnt_d     = cnt_inc;
      win_ovf_d = win_ovf_q || beat_ovf;
      for (int i = 0; i < 4; i++) acc_d[i] = wide[i][ACC_W-1:0];
    end
    if (emit) begin
      out_n_d   = ACC_W'(cnt_inc);
      ovf_d     = win_ovf_q || beat_ovf;
      cnt_d     = '0;
      win_ovf_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
        sum_d[i] = accept ? wide[i][ACC_W-1:0] : acc_q[i];
        acc_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      win_ovf_q <= 1'b0;
      out_n_q   <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
        sum_q[i] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      win_ovf_q <= win_ovf_d;
      out_n_q   <= out_n_d;
      ovf_q     <= ovf_d;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= acc_d[i];
        sum_q[i] <= sum_d[i];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum1      = sum_q[0];
  assign sum2      = sum_q[1];
  assign sum3      = sum_q[2];
  assign sum4      = sum_q[3];
  assign out_n     = out_n_q;
  assign ovf       = ovf_q;

endmodule
